// File: rtl/mem_burst_master.sv
// Burst engine: splits one addr/len/dir command into single-beat valid/ready memory accesses.
// Latency: read beat k valid in cycle 3+2k, done in 2N+1; write done in 3N+1 (5N+1 with WR_VERIFY_EN).
// Backpressure: holds in FETCH until write data arrives; WAIT aborts after TIMEOUT cycles without mem_ready_i.
module mem_burst_master #(
  parameter int DEPTH      = 64,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MAX_LEN    = 16,
  parameter int LEN_WIDTH  = $clog2(MAX_LEN) + 1,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  wr_data_valid_i,
  output logic                  wr_data_ready_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_data_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

`ifdef WR_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE, S_VISSUE, S_VWAIT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_t;
`endif

  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [WIDTH-1:0]      wdata_q;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  wr_q;
  logic                  err_q;

  logic cmd_acc, wr_acc, in_wait, tmo_expired, last_beat, beat_done, rd_capture;

  assign cmd_acc    = cmd_valid_i && (state_q == S_IDLE);
  assign wr_acc     = wr_data_valid_i && (state_q == S_FETCH);
  assign last_beat  = (beat_cnt == len_q - LEN_WIDTH'(1));
  assign rd_capture = (state_q == S_WAIT) && mem_ready_i && !wr_q;
`ifdef WR_VERIFY_EN
  assign in_wait    = (state_q == S_WAIT) || (state_q == S_VWAIT);
  // A write beat only counts once its verify read has returned.
  assign beat_done  = rd_capture || ((state_q == S_VWAIT) && mem_ready_i);
`else
  assign in_wait    = (state_q == S_WAIT);
  assign beat_done  = in_wait && mem_ready_i;
`endif
  assign tmo_expired = in_wait && !mem_ready_i && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_len_i == '0) state_nxt = S_DONE;
          else if (cmd_wr_i)   state_nxt = S_FETCH;
          else                 state_nxt = S_ISSUE;
        end
      end
      S_FETCH: if (wr_data_valid_i) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_ready_i) begin
`ifdef WR_VERIFY_EN
          if (wr_q)           state_nxt = S_VISSUE;
          else if (last_beat) state_nxt = S_DONE;
          else                state_nxt = S_ISSUE;
`else
          if (last_beat)      state_nxt = S_DONE;
          else if (wr_q)      state_nxt = S_FETCH;
          else                state_nxt = S_ISSUE;
`endif
        end else if (tmo_expired) begin
          state_nxt = S_DONE;
        end
      end
`ifdef WR_VERIFY_EN
      S_VISSUE: state_nxt = S_VWAIT;
      S_VWAIT: begin
        if (mem_ready_i)      state_nxt = last_beat ? S_DONE : S_FETCH;
        else if (tmo_expired) state_nxt = S_DONE;
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o     = (state_q == S_IDLE);
    busy_o          = (state_q != S_IDLE);
    wr_data_ready_o = (state_q == S_FETCH);
`ifdef WR_VERIFY_EN
    mem_valid_o     = (state_q == S_ISSUE) || (state_q == S_VISSUE);
`else
    mem_valid_o     = (state_q == S_ISSUE);
`endif
    mem_wr_rd_en_o  = (state_q == S_ISSUE) && wr_q;
    done_o          = (state_q == S_DONE);
    err_o           = (state_q == S_DONE) && err_q;
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q          <= '0;
      len_q           <= '0;
      beat_cnt        <= '0;
      wdata_q         <= '0;
      tmo_cnt         <= '0;
      wr_q            <= 1'b0;
      err_q           <= 1'b0;
      rd_data_o       <= '0;
      rd_data_valid_o <= 1'b0;
    end else begin
      rd_data_valid_o <= 1'b0;
      if (cmd_acc) begin
        addr_q   <= cmd_addr_i;
        len_q    <= cmd_len_i;
        wr_q     <= cmd_wr_i;
        beat_cnt <= '0;
        err_q    <= (cmd_len_i == '0);
      end
      if (wr_acc) wdata_q <= wr_data_i;
      // Counts consecutive idle WAIT cycles; cleared outside WAIT so each beat starts fresh.
      if (in_wait && !mem_ready_i) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                         tmo_cnt <= '0;
      if (tmo_expired) err_q <= 1'b1;
      if (rd_capture) begin
        rd_data_o       <= mem_rdata_i;
        rd_data_valid_o <= 1'b1;
      end
`ifdef WR_VERIFY_EN
      if ((state_q == S_VWAIT) && mem_ready_i && (mem_rdata_i != wdata_q)) err_q <= 1'b1;
`endif
      if (beat_done) begin
        addr_q   <= (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
        beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a registered-ready memory stub.
module tb_mem_burst_master;

`ifdef WR_VERIFY_EN
  localparam int VMUL = 2;
`else
  localparam int VMUL = 1;
`endif
  localparam int WCYC = 1 + 2 * VMUL;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_wr_i;
  logic [5:0]  cmd_addr_i;
  logic [4:0]  cmd_len_i;
  logic [15:0] wr_data_i;
  logic        wr_data_valid_i, wr_data_ready_o;
  logic [15:0] rd_data_o;
  logic        rd_data_valid_o, busy_o, done_o, err_o;
  logic        mem_valid_o, mem_wr_rd_en_o;
  logic [5:0]  mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_ready_i = 1'b0;
  logic [15:0] mem_rdata_i = '0;

  mem_burst_master dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wr_data_i(wr_data_i), .wr_data_valid_i(wr_data_valid_i), .wr_data_ready_o(wr_data_ready_o),
    .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .mem_valid_o(mem_valid_o), .mem_wr_rd_en_o(mem_wr_rd_en_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory stub: ready and rdata registered one cycle after the valid pulse.
  logic [15:0] mem [64];
  logic        stall = 1'b0;
  always @(posedge clk_i) begin
    mem_ready_i <= 1'b0;
    if (!rst_i) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (mem_valid_o && !stall) begin
      mem_ready_i <= 1'b1;
      if (mem_wr_rd_en_o) mem[mem_addr_o] <= mem_wdata_o;
      mem_rdata_i <= mem[mem_addr_o];
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [15:0] wtab [17];
  int          rd_n, mv_n, done_cyc, wr_idx;
  int          rd_cyc [16];
  logic [15:0] rd_val [16];
  logic [5:0]  mv_addr [32];
  logic        mv_wr [32];
  logic [15:0] mv_dat [32];
  logic        err_seen;

  task automatic run_burst(input logic wr, input logic [5:0] addr, input logic [4:0] len);
    int  cyc;
    logic take;
    rd_n = 0; mv_n = 0; done_cyc = 999; err_seen = 1'b0; wr_idx = 0;
    cmd_wr_i = wr; cmd_addr_i = addr; cmd_len_i = len; cmd_valid_i = 1'b1;
    wr_data_i = wtab[0]; wr_data_valid_i = wr;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    cyc = 1;
    while (cyc <= 80 && done_cyc == 999) begin
      if (rd_data_valid_o && rd_n < 16) begin
        rd_cyc[rd_n] = cyc; rd_val[rd_n] = rd_data_o; rd_n++;
      end
      if (mem_valid_o) begin
        if (mv_n < 32) begin
          mv_addr[mv_n] = mem_addr_o; mv_wr[mv_n] = mem_wr_rd_en_o; mv_dat[mv_n] = mem_wdata_o;
        end
        mv_n++;
      end
      if (done_o) begin done_cyc = cyc; err_seen = err_o; end
      take = wr_data_ready_o && wr_data_valid_i;
      @(posedge clk_i); #1;
      cyc++;
      if (take && wr_idx < 16) begin wr_idx++; wr_data_i = wtab[wr_idx]; end
    end
    wr_data_valid_i = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [5:0] a0, input int len);
    logic [5:0] a;
    check({tag, "_pulses"}, mv_n, len * VMUL);
    for (int i = 0; i < len; i++) begin
      a = a0 + 6'(i);
      check({tag, "_addr"}, mv_addr[i * VMUL], a);
      check({tag, "_wr"},   mv_wr[i * VMUL], 1'b1);
      check({tag, "_wdat"}, mv_dat[i * VMUL], wtab[i]);
      check({tag, "_mem"},  mem[a], wtab[i]);
    end
    check({tag, "_done"}, done_cyc, WCYC * len + 1);
    check({tag, "_err"},  err_seen, 1'b0);
  endtask

  task automatic check_read(input string tag, input int len);
    check({tag, "_beats"}, rd_n, len);
    for (int i = 0; i < len; i++) begin
      check({tag, "_cyc"}, rd_cyc[i], 3 + 2 * i);
      check({tag, "_dat"}, rd_val[i], wtab[i]);
    end
    check({tag, "_done"}, done_cyc, 2 * len + 1);
    check({tag, "_err"},  err_seen, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b0;
    cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wr_data_i = '0; wr_data_valid_i = 1'b0;
    for (int i = 0; i < 17; i++) wtab[i] = 16'h00A1 + 16'(i);

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_mem_valid", mem_valid_o, 1'b0);
    check("rst_done_err", {done_o, err_o}, 2'b00);
    check("rst_rd", {rd_data_valid_o, rd_data_o}, 17'h0);
    check("rst_wr_rdy", wr_data_ready_o, 1'b0);
    check("rst_addr", mem_addr_o, 6'd0);
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("idle_cmd_ready", cmd_ready_o, 1'b1);
    check("idle_busy", busy_o, 1'b0);

    // Write then read back at addr 5
    run_burst(1'b1, 6'd5, 5'd4);
    check_write("wr5", 6'd5, 4);
    run_burst(1'b0, 6'd5, 5'd4);
    check_read("rd5", 4);
    check("rd5_addr0", mv_addr[0], 6'd5);
    check("rd5_addr3", mv_addr[3], 6'd8);

    // Address wrap at the top of memory
    for (int i = 0; i < 17; i++) wtab[i] = 16'h00B1 + 16'(i);
    run_burst(1'b1, 6'd62, 5'd4);
    check_write("wr62", 6'd62, 4);
    run_burst(1'b0, 6'd62, 5'd4);
    check_read("rd62", 4);

    // Zero-length command
    run_burst(1'b0, 6'd3, 5'd0);
    check("len0_pulses", mv_n, 0);
    check("len0_done", done_cyc, 1);
    check("len0_err", err_seen, 1'b1);

    // Memory never answers: abort after 8 WAIT cycles
    stall = 1'b1;
    run_burst(1'b0, 6'd0, 5'd3);
    check("tmo_pulses", mv_n, 1);
    check("tmo_beats", rd_n, 0);
    check("tmo_done", done_cyc, 10);
    check("tmo_err", err_seen, 1'b1);
    stall = 1'b0;

    // Reset during ISSUE
    cmd_wr_i = 1'b1; cmd_addr_i = 6'd10; cmd_len_i = 5'd4; cmd_valid_i = 1'b1;
    wr_data_i = 16'h5A5A; wr_data_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("mid_issue", mem_valid_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    check("mid_rst_valid", mem_valid_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    wr_data_valid_i = 1'b0;
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("mid_rst_ready", cmd_ready_o, 1'b1);
    check("mid_rst_mem", mem[10], 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
